// File: rtl/julia_row_scheduler.sv
// Julia-set frame scheduler: hands rows to idle workers and funnels their
// pixel writes through a round-robin arbiter into video-buffer port A.
module julia_row_scheduler #(
    parameter int NUM_WORKERS = 4,
    parameter int NUM_ROWS    = 480
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [NUM_WORKERS-1:0]      worker_busy,
    output logic [NUM_WORKERS-1:0]      worker_start,
    output logic [8:0]                  worker_row,
    input  logic [NUM_WORKERS-1:0]      wr_req,
    input  logic [19*NUM_WORKERS-1:0]   wr_addr,
    input  logic [4*NUM_WORKERS-1:0]    wr_data,
    output logic [NUM_WORKERS-1:0]      wr_grant,
    output logic [18:0]                 mem_addr,
    output logic [3:0]                  mem_data,
    output logic                        mem_we,
    output logic                        frame_done
);

    localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam logic [8:0] LAST_ROW = 9'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [8:0]             row_q, row_d;
    logic [NUM_WORKERS-1:0] claimed_q, claimed_d;
    logic [NUM_WORKERS-1:0] start_q, start_d;
    logic [8:0]             wrow_q, wrow_d;
    logic                   done_q, done_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [18:0]            addr_q, addr_d;
    logic [3:0]             data_q, data_d;

    logic [NUM_WORKERS-1:0] avail;
    logic [NUM_WORKERS-1:0] pick_oh;
    logic [NUM_WORKERS-1:0] grant_c;
    logic [PW-1:0]          gidx;
    logic                   found;

    // A claimed worker stays unavailable until it shows busy at least once.
    assign avail   = ~worker_busy & ~claimed_q;
    assign pick_oh = avail & (~avail + NUM_WORKERS'(1));

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        claimed_d = claimed_q & ~worker_busy;
        start_d   = '0;
        wrow_d    = wrow_q;
        done_d    = done_q;
        if (frame_start) begin
            state_d   = DISPATCH;
            row_d     = '0;
            claimed_d = '0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                DISPATCH: begin
                    if (|avail) begin
                        start_d   = pick_oh;
                        wrow_d    = row_q;
                        claimed_d = claimed_d | pick_oh;
                        row_d     = row_q + 9'd1;
                        if (row_q == LAST_ROW) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (claimed_q == '0 && worker_busy == '0 && wr_req == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    // Round-robin search starting at the pointer; runs regardless of FSM state.
    always_comb begin
        found   = 1'b0;
        gidx    = ptr_q;
        grant_c = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            if (!found && wr_req[(int'(ptr_q) + k) % NUM_WORKERS]) begin
                found = 1'b1;
                gidx  = PW'((int'(ptr_q) + k) % NUM_WORKERS);
            end
        end
        if (found) begin
            grant_c[gidx] = 1'b1;
        end
        ptr_d  = found ? PW'((int'(gidx) + 1) % NUM_WORKERS) : ptr_q;
        we_d   = found;
        addr_d = found ? wr_addr[19*gidx +: 19] : addr_q;
        data_d = found ? wr_data[4*gidx +: 4] : data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            claimed_q <= '0;
            start_q   <= '0;
            wrow_q    <= '0;
            done_q    <= 1'b0;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            claimed_q <= claimed_d;
            start_q   <= start_d;
            wrow_q    <= wrow_d;
            done_q    <= done_d;
            ptr_q     <= ptr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign wr_grant     = reset ? '0 : grant_c;
    assign worker_start = start_q;
    assign worker_row   = wrow_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign frame_done   = done_q;

endmodule

// File: tb/tb_julia_row_scheduler.sv
// Randomised bench for julia_row_scheduler: behavioural workers drive the
// DUT while a rule-level model predicts dispatches, grants and writes.
module tb_julia_row_scheduler;

    localparam int NW = 4;
    localparam int NR = 480;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic [NW-1:0]     worker_busy = '0;
    logic [NW-1:0]     wr_req = '0;
    logic [19*NW-1:0]  wr_addr = '0;
    logic [4*NW-1:0]   wr_data = '0;
    logic [NW-1:0]     worker_start;
    logic [8:0]        worker_row;
    logic [NW-1:0]     wr_grant;
    logic [18:0]       mem_addr;
    logic [3:0]        mem_data;
    logic              mem_we;
    logic              frame_done;

    julia_row_scheduler #(.NUM_WORKERS(NW), .NUM_ROWS(NR)) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (frame_start),
        .worker_busy  (worker_busy),
        .worker_start (worker_start),
        .worker_row   (worker_row),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_grant     (wr_grant),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int            ptr_m, rows_m;
    bit            enabled, done_m;
    logic [NW-1:0] pend;
    logic [NW-1:0] exp_start;
    int            exp_row;
    bit            exp_we;
    logic [18:0]   exp_addr;
    logic [3:0]    exp_data;
    int            wait_c [NW];
    int            seen [NR];
    int            starts_per [NW];

    // Behavioural workers
    bit            auto_w = 0;
    bit            dead0 = 0;
    logic [NW-1:0] last_grant = '0;
    logic [NW-1:0] last_start = '0;
    logic [8:0]    last_row = '0;
    int            phase [NW];
    int            cnt [NW];
    logic [8:0]    job [NW];

    task automatic workers_update();
        for (int i = 0; i < NW; i++) begin
            if (last_grant[i]) wr_req[i] = 1'b0;
            if (dead0 && i == 0) begin
                worker_busy[0] = 1'b0;
            end else begin
                if (last_start[i]) begin
                    job[i]   = last_row;
                    phase[i] = 1;
                    cnt[i]   = int'($urandom_range(0, 2));
                end
                if (phase[i] == 1) begin
                    if (cnt[i] == 0) begin
                        phase[i] = 2;
                        worker_busy[i] = 1'b1;
                        cnt[i] = int'($urandom_range(1, 5));
                    end else begin
                        cnt[i]--;
                    end
                end else if (phase[i] == 2) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                    end else if (!wr_req[i]) begin
                        worker_busy[i] = 1'b0;
                        wr_req[i] = 1'b1;
                        wr_addr[19*i +: 19] = {job[i], 10'(i)};
                        wr_data[4*i +: 4] = job[i][3:0] ^ 4'(i);
                        phase[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic workers_clear();
        for (int i = 0; i < NW; i++) begin
            phase[i] = 0;
            cnt[i] = 0;
        end
        worker_busy = '0;
        wr_req = '0;
    endtask

    // Predict what the next rising edge must register, from current inputs.
    task automatic predict();
        logic [NW-1:0] g;
        logic [NW-1:0] avail;
        int gi;
        if (reset) begin
            chk("grant_in_reset", wr_grant, '0);
            ptr_m = 0; rows_m = 0; enabled = 0; done_m = 0; pend = '0;
            exp_start = '0; exp_row = 0; exp_we = 0; exp_addr = '0; exp_data = '0;
            for (int i = 0; i < NW; i++) wait_c[i] = 0;
            last_grant = '0;
        end else begin
            g = '0;
            gi = -1;
            for (int k = 0; k < NW; k++) begin
                if (gi < 0 && wr_req[(ptr_m + k) % NW]) gi = (ptr_m + k) % NW;
            end
            if (gi >= 0) g[gi] = 1'b1;
            chk("wr_grant", wr_grant, g);
            exp_we = (gi >= 0);
            if (gi >= 0) begin
                exp_addr = wr_addr[19*gi +: 19];
                exp_data = wr_data[4*gi +: 4];
                ptr_m = (gi + 1) % NW;
                chk("rr_wait_bound", wait_c[gi] < NW, 1);
            end
            for (int i = 0; i < NW; i++) begin
                if (wr_req[i] && !g[i]) wait_c[i]++;
                else wait_c[i] = 0;
            end
            last_grant = wr_grant;
            pend |= worker_start;
            exp_start = '0;
            if (frame_start) begin
                rows_m = 0; enabled = 1; done_m = 0; pend = '0;
                for (int r = 0; r < NR; r++) seen[r] = 0;
                for (int i = 0; i < NW; i++) starts_per[i] = 0;
            end else begin
                if (enabled && rows_m < NR) begin
                    avail = ~worker_busy & ~pend;
                    for (int i = 0; i < NW; i++) begin
                        if (avail[i] && exp_start == '0) exp_start[i] = 1'b1;
                    end
                    if (exp_start != '0) begin
                        exp_row = rows_m;
                        rows_m++;
                    end
                end else if (enabled && pend == '0 && worker_busy == '0 && wr_req == '0) begin
                    done_m = 1;
                end
                pend &= ~worker_busy;
            end
        end
    endtask

    task automatic check_regs();
        chk("worker_start", worker_start, exp_start);
        if (exp_start != '0) chk("worker_row", worker_row, exp_row);
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_data", mem_data, exp_data);
        end
        chk("frame_done", frame_done, done_m);
        for (int i = 0; i < NW; i++) if (worker_start[i]) starts_per[i]++;
        if (worker_start != '0 && worker_row < NR) seen[worker_row]++;
        last_start = worker_start;
        last_row = worker_row;
    endtask

    task automatic cycle();
        if (auto_w) workers_update();
        #1;
        predict();
        @(posedge clock);
        #1;
        check_regs();
    endtask

    int bad, budget, wrote;
    logic [NW-1:0] old_req;

    initial begin
        for (int i = 0; i < NW; i++) begin
            phase[i] = 0; cnt[i] = 0; job[i] = '0; starts_per[i] = 0;
        end
        // Requests during reset must never be granted
        reset = 1'b1;
        wr_req = '1;
        repeat (3) cycle();
        wr_req = '0;
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_worker_start", worker_start, '0);
        chk("rst_worker_row", worker_row, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_frame_done", frame_done, 0);

        // Arbiter with all four requesting, pointer at 0
        for (int i = 0; i < NW; i++) begin
            wr_addr[19*i +: 19] = 19'(32'h100 + i);
            wr_data[4*i +: 4] = 4'(i + 5);
        end
        wr_req = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_seq_grant", last_grant, 32'(1) << (k % NW));
            chk("rr_seq_we", mem_we, 1);
            chk("rr_seq_addr", mem_addr, 32'h100 + (k % NW));
        end
        wr_req = '0;
        cycle();
        chk("rr_idle_we", mem_we, 0);

        // Idle workers get rows 0..3 in consecutive cycles
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("idle_disp_start", worker_start, 32'(1) << k);
            chk("idle_disp_row", worker_row, k);
        end
        repeat (4) cycle();

        // Worker 0 never acknowledges; then reset while draining
        workers_clear();
        auto_w = 1; dead0 = 1;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        budget = 0;
        while (rows_m < NR && budget < 20000) begin
            cycle();
            budget++;
        end
        chk("dead0_all_rows", rows_m, NR);
        repeat (3) cycle();
        chk("dead0_single_row", starts_per[0], 1);
        chk("dead0_not_done", frame_done, 0);
        auto_w = 0; dead0 = 0;
        workers_clear();
        wr_req = 4'b0100;
        wr_addr[38 +: 19] = 19'h5a5a5;
        reset = 1'b1;
        cycle();
        chk("drain_rst_grant", last_grant, 0);
        chk("drain_rst_we", mem_we, 0);
        chk("drain_rst_done", frame_done, 0);
        reset = 1'b0;
        wr_req = '0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_rst_idle_start", worker_start, 0);
            chk("post_rst_idle_done", frame_done, 0);
        end

        // Full frame with randomised workers
        workers_clear();
        auto_w = 1;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        budget = 0;
        while (!frame_done && budget < 30000) begin
            cycle();
            budget++;
        end
        chk("full_frame_done", frame_done, 1);
        bad = 0;
        for (int r = 0; r < NR; r++) if (seen[r] != 1) bad++;
        chk("rows_once", bad, 0);
        chk("done_workers_idle", {worker_busy, wr_req}, 0);

        // Restart mid-frame at row 200
        workers_clear();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        budget = 0;
        while (!(last_start != '0 && last_row == 9'd200) && budget < 20000) begin
            cycle();
            budget++;
        end
        chk("reached_row_200", last_row, 200);
        cycle();
        old_req = wr_req;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        wrote = 0;
        budget = 0;
        while (last_start == '0 && budget < 20) begin
            cycle();
            if (mem_we) wrote++;
            budget++;
        end
        chk("restart_row", last_row, 0);
        chk("restart_dispatched", last_start != '0, 1);
        repeat (NW + 1) begin
            cycle();
            if (mem_we) wrote++;
        end
        if (old_req != '0) chk("old_write_seen", wrote > 0, 1);
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/julia_row_scheduler.md
JULIA_ROW_SCHEDULER -- requirements
Module: julia_row_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_WORKERS, default 4, meaning the number of row-compute workers served.
REQ-002 The module SHALL have parameter NUM_ROWS, default 480, meaning the rows per frame, numbered 0..NUM_ROWS-1.
REQ-003 Reset: reset, synchronous, active-high; clock: clock.
REQ-004 clock  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 frame_start  in  1  one-cycle pulse; begins (or restarts) a frame.
REQ-007 worker_busy  in  NUM_WORKERS  per-worker busy level.
REQ-008 worker_start  out  NUM_WORKERS  one-cycle dispatch pulse, at most one bit set.
REQ-009 worker_row  out  9  row index for the pulsed worker; valid only with worker_start.
REQ-010 wr_req  in  NUM_WORKERS  per-worker pixel-write request, held until granted.
REQ-011 wr_addr  in  19*NUM_WORKERS  flattened write addresses; worker i at bits [19i+18:19i].
REQ-012 wr_data  in  4*NUM_WORKERS  flattened 4-bit pixel codes; worker i at bits [4i+3:4i].
REQ-013 wr_grant  out  NUM_WORKERS  combinational one-hot grant, same cycle as the request.
REQ-014 mem_addr / mem_data / mem_we  out  19 / 4 / 1  registered video-buffer port-A write.
REQ-015 frame_done  out  1  level; high once the frame is complete.

Function
REQ-016 FSM states SHALL be IDLE, DISPATCH, DRAIN, DONE.
REQ-017 IDLE->DISPATCH on frame_start; the row counter is cleared to 0.
REQ-018 In DISPATCH, at most one row per cycle SHALL go to the lowest-index available worker.
- Available: worker_busy[i]=0 and claimed[i]=0.
- On dispatch: worker_start[i]=1, worker_row=row counter, claimed[i] set, row counter +1.
REQ-019 claimed[i] SHALL clear on the first cycle worker_busy[i]=1, so a worker is never re-dispatched before it acknowledges.
REQ-020 DISPATCH->DRAIN in the cycle the row NUM_ROWS-1 is dispatched; no row SHALL be dispatched twice or skipped.
REQ-021 DRAIN->DONE when all claimed=0, all worker_busy=0 and wr_req=0 in the same cycle; frame_done is set on entry to DONE.
REQ-022 frame_start in any state (DISPATCH, DRAIN, DONE) SHALL restart.
- Row counter cleared to 0, all claimed bits cleared, frame_done cleared, next state DISPATCH.
- The write arbiter is not reset; in-flight writes still complete.
REQ-023 The write arbiter SHALL be round-robin, independent of the FSM.
- Granted index is the first requester at or after the pointer, modulo NUM_WORKERS.
- Pointer advances to granted index +1 and is unchanged with no request.
REQ-024 A grant in cycle t SHALL produce mem_we=1 with the granted worker's addr/data in cycle t+1; mem_we=0 in cycles following no grant.
REQ-025 Exactly one write SHALL be issued per grant; a requester is served within NUM_WORKERS cycles of raising wr_req.
REQ-026 worker_start and wr_grant SHALL be independent; both may be active in the same cycle.

Reset
REQ-027 Reset SHALL take priority over frame_start and force the following values.
- State IDLE; row counter 0; claimed 0; arbiter pointer 0.
- worker_start 0; worker_row 0; mem_we 0; mem_addr 0; mem_data 0; frame_done 0.
REQ-028 Reset mid-frame SHALL abandon the frame; wr_grant stays 0 while reset is high.

Verification
REQ-029 Idle bus, frame_start -> worker_start 0001,0010,0100,1000 in four consecutive cycles with worker_row 0,1,2,3.
REQ-030 Worker 0 never raises busy -> it never receives a second row; rows go only to workers 1-3.
REQ-031 wr_req=1111 held for 8 cycles, pointer 0 -> grants 0,1,2,3,0,1,2,3; mem_we high cycles 2-9 with the matching addresses.
REQ-032 Full 480-row model run -> each row 0..479 dispatched exactly once; frame_done rises only after the last busy falls and the last write is issued.
REQ-033 frame_start at row 200 -> next dispatch carries worker_row 0; the pending write from the old frame still appears on mem_*.
REQ-034 reset asserted during DRAIN with wr_req=0100 -> next cycle mem_we 0, frame_done 0, no grant; after release the FSM stays in IDLE.
